// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_t       : converter FSM states
//   BCD_DIGIT_MAX : largest legal BCD digit
//   bin_w_min()   : smallest binary width that holds 10^digits - 1
package bcd2bin_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Smallest w with 2^w > 10^digits - 1. Bounded loop keeps it a plain
  // constant function for elaboration.
  function automatic int bin_w_min(input int digits);
    longint p;
    int     w;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    w = 0;
    for (int i = 1; i < 63; i++)
      if (w == 0 && (longint'(1) << i) > p - 1) w = i;
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-10-and-add stage for one BCD digit.
//   acc       in  : running binary accumulator
//   digit     in  : BCD digit to fold in
//   acc_nxt   out : acc*10 + digit (don't-care when digit_bad)
//   digit_bad out : digit is above 9
module bcd_mac10
  import bcd2bin_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_nxt,
  output logic             digit_bad
);

  // x*10 as x*8 + x*2: two shifts and an adder, no multiplier.
  assign acc_nxt   = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign digit_bad = (digit > BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential multi-digit BCD-to-binary converter, MS digit first, one
// digit per clock, with per-digit legality checking.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input handshake (ready only in IDLE)
//   bcd                  : DIGITS packed BCD digits, digit DIGITS-1 is MS
//   out_valid/out_ready  : output handshake (valid only in DONE)
//   binary               : converted value, 0 when error
//   error                : some digit was above 9
//   err_digit            : index of the most significant illegal digit
// Build option: define BCD2BIN_EARLY_ABORT_EN to finish a word on the
// first illegal digit instead of always spending DIGITS conversion edges.
module bcd_to_binary_seq
  import bcd2bin_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int BIN_W  = 14,
  localparam int EW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      binary,
  output logic                  error,
  output logic [EW-1:0]         err_digit
);

  if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
    $error("bcd_to_binary_seq: DIGITS must be in 1..9");
  end
  if (BIN_W < bin_w_min(DIGITS)) begin : g_bad_bin_w
    $error("bcd_to_binary_seq: BIN_W too narrow for 10^DIGITS-1");
  end

  state_t                state, state_n;
  logic [4*DIGITS-1:0]   word;
  logic [BIN_W-1:0]      acc;
  logic [EW-1:0]         idx;
  logic                  err_q;
  logic [EW-1:0]         ed_q;

  logic [BIN_W-1:0]      acc_nxt;
  logic                  digit_bad;

  // The latched word is shifted left each CONV edge, so the digit being
  // processed always sits in the top nibble; idx tracks its position.
  bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
    .acc       (acc),
    .digit     (word[4*DIGITS-1 -: 4]),
    .acc_nxt   (acc_nxt),
    .digit_bad (digit_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = CONV;
      CONV: begin
        if (idx == '0) state_n = DONE;
`ifdef BCD2BIN_EARLY_ABORT_EN
        if (digit_bad) state_n = DONE;
`endif
      end
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      acc   <= '0;
      idx   <= '0;
      err_q <= 1'b0;
      ed_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word  <= bcd;
          acc   <= '0;
          idx   <= EW'(DIGITS - 1);
          err_q <= 1'b0;
          ed_q  <= '0;
        end
        CONV: begin
          word <= word << 4;
          idx  <= idx - EW'(1);
          if (digit_bad) begin
            err_q <= 1'b1;
            // First bad digit seen is the most significant one.
            if (!err_q) ed_q <= idx;
          end else begin
            acc <= acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign error     = err_q;
  assign err_digit = ed_q;
  assign binary    = err_q ? '0 : acc;

endmodule
